ti_sbox_sched: RTL and testbench
================================

Name: ti_sbox_sched

Overview:
- Sequencing controller for the pipelined threshold-implementation (TI) 4-bit S-box datapath: the shared coordinate-function stages with registers between stages.
- Takes a full shared cipher state and issues it through one external S-box instance, one nibble (all shares together) per cycle.
- Tracks in-flight nibbles across the fixed datapath latency and reassembles the shared result state.
- Sits between the round-control FSM and the S-box datapath, so a single TI S-box instance serves the whole substitution layer.

Parameters:
- NNIB, 16, nibbles per state.
- SHARES, 3, number of Boolean shares per nibble.
- SB_LAT, 2, datapath latency in cycles from sb_vld to a valid sb_out (number of register stages); minimum 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a substitution layer; sampled only in IDLE.
- hold  input  1  pause issuing new nibbles; in-flight nibbles still complete.
- st_in  input  SHARES*NNIB*4  shared state; share s, nibble i at bits [(s*NNIB+i)*4 +: 4].
- rnd  input  8  fresh randomness per issue; used only with the optional feature.
- sb_in  output  SHARES*4  nibble shares to datapath; share s at [s*4 +: 4].
- sb_vld  output  1  sb_in valid this cycle.
- sb_out  input  SHARES*4  datapath result; valid SB_LAT cycles after the matching sb_vld.
- st_out  output  SHARES*NNIB*4  shared result state, same packing as st_in.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when st_out is complete.

Behaviour:
- Reset values: state IDLE; sb_in, sb_vld, st_out, busy, done all 0; issue and collect counters 0; in-flight valid pipe cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches st_in into the internal state register, zeroes both counters, moves to ISSUE.
  - st_out holds its previous value.
- ISSUE:
  - Each cycle with hold=0: drive nibble issue_cnt of every share on sb_in, sb_vld=1, issue_cnt++.
  - With hold=1: sb_vld=0 and sb_in=0. Never leave stale shares on the bus.
  - After issuing nibble NNIB-1, go to DRAIN.
- Collection, active in ISSUE and DRAIN:
  - A SB_LAT-deep shift register carries the valid bit and nibble index alongside each issue.
  - When its output is valid, write sb_out into st_out slot [index] for every share and increment collect_cnt.
  - Results land in issue order; hold bubbles produce no writes.
- DRAIN:
  - sb_vld=0.
  - When the write of nibble NNIB-1 occurs, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1, then IDLE.
  - st_out is stable from the DONE cycle until the next layer's first write.
- Latency, with start sampled in cycle t and no hold:
  - nibble i issued in cycle t+1+i;
  - written at the end of cycle t+1+i+SB_LAT;
  - done in cycle t+NNIB+SB_LAT+1 (t+19 with defaults).
  - Each hold cycle during ISSUE adds exactly one cycle.
- Boundaries:
  - start while busy is ignored.
  - start in the DONE cycle is ignored; it is accepted from the following IDLE cycle.
  - hold in DRAIN or DONE has no effect.
  - rst mid-operation returns to IDLE next edge; in-flight results are discarded and st_out cleared to 0.
  - Counters are width clog2(NNIB)+1 and never wrap within a layer.
- Shares are never combined inside the block: no XOR across shares of the same nibble except as defined under the optional feature.

Optional Feature:
- Macro SB_REMASK_EN.
- Defined: each issued nibble is refreshed before reaching sb_in.
  - share0 ^= rnd[3:0]
  - share1 ^= rnd[7:4]
  - share2 ^= rnd[3:0]^rnd[7:4]
  - Other shares pass unchanged.
  - The unshared value is preserved; rnd is sampled in the issue cycle.
- Undefined: rnd is unused and shares pass to sb_in unchanged.

Test Plan:
- Bench datapath stub: SB_LAT-cycle delay line that XORs share0 with 4'hF, so the unshared output is NOT of the input.
- 1. Reset then start, st_in with share0 nibbles = 0..15 and shares 1,2 = 0 -> sb_vld high cycles t+1..t+16; done at t+19; unshared st_out nibble i = ~i; busy low at t+20.
- 2. Random shares of state 64'h0123456789ABCDEF -> XOR of the st_out shares = 64'hFEDCBA9876543210.
- 3. hold=1 for cycles t+5..t+7 -> sb_vld low and sb_in=0 there; done at t+22; result identical to case 1.
- 4. start pulsed at t+3 and at the done cycle -> both ignored; exactly one done pulse; next start accepted in IDLE.
- 5. rst=1 at t+10 for one cycle -> IDLE, st_out=0, busy=0, no done; a new start completes correctly.
- 6. With SB_REMASK_EN, rnd=8'hA5 every cycle -> share0/share1/share2 on sb_in differ from st_in by 5/A/F; unshared st_out unchanged vs case 2.

Source files
------------

// File: rtl/ti_sbox_sched.sv
// ============================================================================
// Module   : ti_sbox_sched
// Purpose  : Issues a shared cipher state one nibble per cycle through a
//            single pipelined TI S-box and reassembles the shared result.
//            Optional macro SB_REMASK_EN refreshes shares with rnd at issue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ti_sbox_sched #(
    parameter int NNIB   = 16,
    parameter int SHARES = 3,
    parameter int SB_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       hold,
    input  logic [SHARES*NNIB*4-1:0]   st_in,
    input  logic [7:0]                 rnd,
    output logic [SHARES*4-1:0]        sb_in,
    output logic                       sb_vld,
    input  logic [SHARES*4-1:0]        sb_out,
    output logic [SHARES*NNIB*4-1:0]   st_out,
    output logic                       busy,
    output logic                       done
);

    localparam int c_CW = $clog2(NNIB) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NNIB - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [SHARES*NNIB*4-1:0]    r_st;
    logic [SHARES*NNIB*4-1:0]    r_out;
    logic [c_CW-1:0]             r_issue_cnt;
    logic [c_CW-1:0]             r_coll_cnt;
    logic [SB_LAT-1:0]           r_vpipe;
    logic [c_CW-1:0]             r_ipipe [SB_LAT];
    logic                        w_issue;
    logic                        w_wr;
    logic [c_CW-1:0]             w_widx;
    logic [SHARES*4-1:0]         w_raw;
    logic [SHARES*4-1:0]         w_mask;

`ifdef SB_REMASK_EN
    // Refresh keeps the XOR of shares 0..2 unchanged: the three masks cancel.
    for (genvar s = 0; s < SHARES; s++) begin : g_mask
        if (s == 0) begin : g_s0
            assign w_mask[s*4 +: 4] = rnd[3:0];
        end else if (s == 1) begin : g_s1
            assign w_mask[s*4 +: 4] = rnd[7:4];
        end else if (s == 2) begin : g_s2
            assign w_mask[s*4 +: 4] = rnd[3:0] ^ rnd[7:4];
        end else begin : g_sn
            assign w_mask[s*4 +: 4] = 4'h0;
        end
    end
`else
    assign w_mask = '0;
    wire w_unused_rnd = ^rnd;
`endif

    assign w_issue = (r_state == S_ISSUE) && !hold;
    assign w_wr    = r_vpipe[SB_LAT-1] && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_widx  = r_ipipe[SB_LAT-1];

    always_comb begin
        w_raw = '0;
        for (int s = 0; s < SHARES; s++) begin
            w_raw[s*4 +: 4] = r_st[(s*NNIB + int'(r_issue_cnt))*4 +: 4];
        end
    end

    // Bus is forced to zero whenever nothing is issued so no stale shares leak.
    assign sb_in  = w_issue ? (w_raw ^ w_mask) : '0;
    assign sb_vld = w_issue;
    assign st_out = r_out;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ISSUE;
            S_ISSUE: if (w_issue && (r_issue_cnt == c_LAST)) w_next = S_DRAIN;
            S_DRAIN: if (w_wr && (r_coll_cnt == c_LAST)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_st        <= '0;
            r_out       <= '0;
            r_issue_cnt <= '0;
            r_coll_cnt  <= '0;
            r_vpipe     <= '0;
            for (int k = 0; k < SB_LAT; k++) begin
                r_ipipe[k] <= '0;
            end
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && start) begin
                r_st        <= st_in;
                r_issue_cnt <= '0;
                r_coll_cnt  <= '0;
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            // Valid/index pipe mirrors the datapath latency.
            for (int k = SB_LAT - 1; k > 0; k--) begin
                r_vpipe[k] <= r_vpipe[k-1];
                r_ipipe[k] <= r_ipipe[k-1];
            end
            r_vpipe[0] <= w_issue;
            r_ipipe[0] <= r_issue_cnt;
            if (w_wr) begin
                r_coll_cnt <= r_coll_cnt + 1'b1;
                for (int s = 0; s < SHARES; s++) begin
                    r_out[(s*NNIB + int'(w_widx))*4 +: 4] <= sb_out[s*4 +: 4];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ti_sbox_sched.sv
// ============================================================================
// Module   : tb_ti_sbox_sched
// Purpose  : Self-checking bench for ti_sbox_sched with a delay-line S-box stub.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ti_sbox_sched;

    localparam int NNIB   = 16;
    localparam int SHARES = 3;
    localparam int SB_LAT = 2;
    localparam int W      = SHARES*NNIB*4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             hold;
    logic [W-1:0]     st_in;
    logic [7:0]       rnd;
    logic [11:0]      sb_in;
    logic             sb_vld;
    logic [11:0]      sb_out;
    logic [W-1:0]     st_out;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ti_sbox_sched #(.NNIB(NNIB), .SHARES(SHARES), .SB_LAT(SB_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .st_in(st_in),
        .rnd(rnd), .sb_in(sb_in), .sb_vld(sb_vld), .sb_out(sb_out),
        .st_out(st_out), .busy(busy), .done(done)
    );

    // Datapath stub: SB_LAT-cycle delay, share0 inverted so unshared out = NOT in.
    logic [11:0] dl [SB_LAT];
    always_ff @(posedge clk) begin
        dl[0] <= sb_in;
        for (int k = 1; k < SB_LAT; k++) dl[k] <= dl[k-1];
    end
    assign sb_out = dl[SB_LAT-1] ^ 12'h00F;

    function automatic logic [63:0] unshare(input logic [W-1:0] st);
        logic [63:0] u;
        u = '0;
        for (int i = 0; i < NNIB; i++)
            for (int s = 0; s < SHARES; s++)
                u[i*4 +: 4] = u[i*4 +: 4] ^ st[(s*NNIB+i)*4 +: 4];
        return u;
    endfunction

    function automatic logic [11:0] remask(input logic [7:0] r);
`ifdef SB_REMASK_EN
        return {r[3:0] ^ r[7:4], r[7:4], r[3:0]};
`else
        return 12'h000;
`endif
    endfunction

    function automatic logic [W-1:0] share3(input logic [63:0] v, input logic [63:0] a,
                                            input logic [63:0] b);
        return {b, a, v ^ a ^ b};
    endfunction

    int           g_done_r, g_exp_done, g_ndone, g_vld_err, g_bus_err;
    logic         g_busy_after;
    logic [W-1:0] g_exp;

    // Drives one layer; start at relative cycle 0, extra start pulses at xs1/xs2,
    // hold over [hf,ht]. Records observations for the calling test to judge.
    task automatic run_layer(input logic [W-1:0] st, input int hf, input int ht,
                             input int xs1, input int xs2, input bit fixed_rnd);
        int issued;
        logic exp_vld;
        logic [11:0] raw, exp_bus;
        issued = 0; g_done_r = -1; g_exp_done = -1; g_ndone = 0;
        g_vld_err = 0; g_bus_err = 0; g_busy_after = 1'bx; g_exp = '0;
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            start = (r == 0) || (r == xs1) || (r == xs2);
            hold  = (r >= hf) && (r <= ht);
            st_in = (r == 0) ? st : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rnd   = fixed_rnd ? 8'hA5 : 8'($urandom);
            #1;
            exp_vld = (r >= 1) && (issued < NNIB) && !hold;
            if (sb_vld !== exp_vld) g_vld_err++;
            if (exp_vld) begin
                for (int s = 0; s < SHARES; s++) raw[s*4 +: 4] = st[(s*NNIB+issued)*4 +: 4];
                exp_bus = raw ^ remask(rnd);
                if (sb_in !== exp_bus) g_bus_err++;
                for (int s = 0; s < SHARES; s++)
                    g_exp[(s*NNIB+issued)*4 +: 4] = exp_bus[s*4 +: 4] ^ ((s == 0) ? 4'hF : 4'h0);
                issued++;
                if (issued == NNIB) g_exp_done = r + SB_LAT + 1;
            end else if (sb_in !== 12'h000) begin
                g_bus_err++;
            end
            if (done === 1'b1) begin
                g_ndone++;
                if (g_done_r < 0) g_done_r = r;
            end
            if ((g_done_r >= 0) && (r == g_done_r + 1)) g_busy_after = busy;
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; hold = 1'b0; st_in = '0; rnd = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (sb_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", sb_vld); end
        checks++; if (sb_in !== 12'h0) begin errors++; $display("FAIL reset_sbin got %h want 0", sb_in); end
        checks++; if (st_out !== '0) begin errors++; $display("FAIL reset_stout got %h want 0", st_out); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [W-1:0] st;
        st = '0;
        for (int i = 0; i < NNIB; i++) st[i*4 +: 4] = 4'(i);
        run_layer(st, 99, 99, -1, -1, 1'b0);
        checks++; if (g_vld_err != 0) begin errors++; $display("FAIL basic_vld_pattern got %0d bad cycles want 0", g_vld_err); end
        checks++; if (g_bus_err != 0) begin errors++; $display("FAIL basic_sbin got %0d bad cycles want 0", g_bus_err); end
        checks++; if (g_done_r != 19) begin errors++; $display("FAIL basic_done_cycle got %0d want 19", g_done_r); end
        checks++; if (g_ndone != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", g_ndone); end
        checks++; if (g_busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", g_busy_after); end
        checks++; if (unshare(st_out) !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL basic_unshared got %h want 0123456789abcdef", unshare(st_out)); end
        checks++; if (st_out !== g_exp) begin errors++; $display("FAIL basic_shares got %h want %h", st_out, g_exp); end
    endtask

    task automatic test_random_shares;
        run_layer(share3(64'h0123456789ABCDEF, {$urandom, $urandom}, {$urandom, $urandom}),
                  99, 99, -1, -1, 1'b0);
        checks++; if (unshare(st_out) !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL rshare_unshared got %h want fedcba9876543210", unshare(st_out)); end
        checks++; if (st_out !== g_exp) begin errors++; $display("FAIL rshare_shares got %h want %h", st_out, g_exp); end
        checks++; if ((g_done_r != 19) || (g_bus_err != 0)) begin errors++; $display("FAIL rshare_timing got done %0d buserr %0d want 19 0", g_done_r, g_bus_err); end
    endtask

    task automatic test_hold;
        logic [W-1:0] st;
        st = '0;
        for (int i = 0; i < NNIB; i++) st[i*4 +: 4] = 4'(i);
        run_layer(st, 5, 7, -1, -1, 1'b0);
        checks++; if (g_vld_err != 0) begin errors++; $display("FAIL hold_vld_pattern got %0d bad cycles want 0", g_vld_err); end
        checks++; if (g_bus_err != 0) begin errors++; $display("FAIL hold_sbin got %0d bad cycles want 0", g_bus_err); end
        checks++; if (g_done_r != 22) begin errors++; $display("FAIL hold_done_cycle got %0d want 22", g_done_r); end
        checks++; if (unshare(st_out) !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL hold_unshared got %h want 0123456789abcdef", unshare(st_out)); end
    endtask

    task automatic test_ignore_start;
        logic [63:0] v;
        v = {$urandom, $urandom};
        run_layer(share3(v, {$urandom, $urandom}, {$urandom, $urandom}), 99, 99, 3, 19, 1'b0);
        checks++; if (g_ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", g_ndone); end
        checks++; if (g_done_r != 19) begin errors++; $display("FAIL ign_done_cycle got %0d want 19", g_done_r); end
        checks++; if (g_busy_after !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b want 0", g_busy_after); end
        checks++; if (unshare(st_out) !== ~v) begin errors++; $display("FAIL ign_unshared got %h want %h", unshare(st_out), ~v); end
        v = {$urandom, $urandom};
        run_layer(share3(v, {$urandom, $urandom}, {$urandom, $urandom}), 99, 99, -1, -1, 1'b0);
        checks++; if ((g_done_r != 19) || (unshare(st_out) !== ~v)) begin errors++; $display("FAIL ign_next_layer got done %0d val %h want 19 %h", g_done_r, unshare(st_out), ~v); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        logic [63:0] v;
        ndone = 0;
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            start = (r == 0);
            rst   = (r == 10);
            st_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            if (done === 1'b1) ndone++;
            if (r == 11) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
                checks++; if (st_out !== '0) begin errors++; $display("FAIL rstmid_stout got %h want 0", st_out); end
                checks++; if (sb_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b want 0", sb_vld); end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
        v = {$urandom, $urandom};
        run_layer(share3(v, {$urandom, $urandom}, {$urandom, $urandom}), 99, 99, -1, -1, 1'b0);
        checks++; if ((g_done_r != 19) || (unshare(st_out) !== ~v) || (st_out !== g_exp)) begin errors++; $display("FAIL rstmid_recover got done %0d val %h want 19 %h", g_done_r, unshare(st_out), ~v); end
    endtask

    task automatic test_random;
        logic [63:0] v;
        int hf, ht;
        for (int n = 0; n < 4; n++) begin
            v  = {$urandom, $urandom};
            hf = int'($urandom_range(1, 10));
            ht = hf + int'($urandom_range(0, 3));
            run_layer(share3(v, {$urandom, $urandom}, {$urandom, $urandom}), hf, ht, -1, -1, 1'b0);
            checks++;
            if ((g_vld_err != 0) || (g_bus_err != 0) || (g_done_r != 19 + ht - hf + 1) ||
                (g_done_r != g_exp_done) || (st_out !== g_exp) || (unshare(st_out) !== ~v)) begin
                errors++;
                $display("FAIL random_%0d got done %0d vld %0d bus %0d val %h want done %0d val %h",
                         n, g_done_r, g_vld_err, g_bus_err, unshare(st_out), 20 + ht - hf, ~v);
            end
        end
    endtask

`ifdef SB_REMASK_EN
    task automatic test_remask;
        run_layer(share3(64'h0123456789ABCDEF, {$urandom, $urandom}, {$urandom, $urandom}),
                  99, 99, -1, -1, 1'b1);
        checks++; if (g_bus_err != 0) begin errors++; $display("FAIL remask_sbin got %0d bad cycles want 0", g_bus_err); end
        checks++; if (unshare(st_out) !== 64'hFEDCBA9876543210) begin errors++; $display("FAIL remask_unshared got %h want fedcba9876543210", unshare(st_out)); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_random_shares;
        test_hold;
        test_ignore_start;
        test_reset_mid;
        test_random;
`ifdef SB_REMASK_EN
        test_remask;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
